// File: rtl/sub32_seq.sv
// Multi-cycle subtractor: x - y computed as x + ~y + 1, CHUNK bits per cycle, valid/ready on both sides.
// Optional signed-overflow flag enabled by defining SUB32_SEQ_OVF_EN (otherwise ovf_out is tied low).
module sub32_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out,
  output logic             out_valid_out,
  input  logic             out_ready_in
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_ny;
  logic [WIDTH-1:0] r_diff;
  logic             r_carry;
  logic             r_borrow;
  logic [IDXW-1:0]  r_idx;
  logic [CHUNK-1:0] w_x_chunk;
  logic [CHUNK-1:0] w_ny_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_last;

  // One chunk of the carry chain per RUN cycle
  always_comb begin
    w_x_chunk  = r_x[int'(r_idx)*CHUNK +: CHUNK];
    w_ny_chunk = r_ny[int'(r_idx)*CHUNK +: CHUNK];
    w_sum      = {1'b0, w_x_chunk} + {1'b0, w_ny_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_last     = (r_idx == LAST_IDX);
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid_in) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        if (out_ready_in) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture, chunk accumulation and borrow
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x      <= {WIDTH{1'b0}};
      r_ny     <= {WIDTH{1'b0}};
      r_diff   <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_idx    <= {IDXW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_in) begin
            r_x     <= x_in;
            r_ny    <= ~y_in;
            r_carry <= 1'b1;
            r_idx   <= {IDXW{1'b0}};
          end
        end
        RUN: begin
          r_diff[int'(r_idx)*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry <= w_sum[CHUNK];
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_borrow <= ~w_sum[CHUNK];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SUB32_SEQ_OVF_EN
  logic r_ovf;

  // Signed overflow: operand signs differ and the result sign departs from x (x[MSB]==~y[MSB] means signs differ)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_x[WIDTH-1] == r_ny[WIDTH-1]) & (w_sum[CHUNK-1] != r_x[WIDTH-1]);
    end
  end

  assign ovf_out = r_ovf;
`else
  assign ovf_out = 1'b0;
`endif

  assign in_ready_out  = (r_state == IDLE);
  assign out_valid_out = (r_state == DONE);
  assign diff_out      = r_diff;
  assign borrow_out    = r_borrow;

endmodule

// File: tb/tb_sub32_seq.sv
// Directed self-checking bench for sub32_seq: arithmetic vectors, latency, backpressure and mid-run reset.
module tb_sub32_seq;

`ifdef SUB32_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [31:0] diff_out;
  logic        borrow_out;
  logic        ovf_out;
  logic        out_valid_out;
  logic        out_ready_in;

  int errors = 0;
  int checks = 0;

  sub32_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .diff_out      (diff_out),
    .borrow_out    (borrow_out),
    .ovf_out       (ovf_out),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, wait for the result, check it and its latency, then let it be consumed.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_d, input logic exp_b, input logic exp_o);
    int cycles;
    @(negedge clk_in);
    check({tag, ".ready"}, {31'd0, in_ready_out}, 32'd1);
    x_in = x;
    y_in = y;
    in_valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    in_valid_in = 1'b0;
    x_in = 32'hA5A5_5A5A;
    y_in = 32'h1234_4321;
    cycles = 0;
    while (!out_valid_out && cycles < 20) begin
      @(posedge clk_in);
      @(negedge clk_in);
      cycles++;
    end
    check({tag, ".latency"}, cycles, 32'd4);
    check({tag, ".diff"}, diff_out, exp_d);
    check({tag, ".borrow"}, {31'd0, borrow_out}, {31'd0, exp_b});
    check({tag, ".ovf"}, {31'd0, ovf_out}, {31'd0, exp_o & OVF_EN});
    @(posedge clk_in);
    @(negedge clk_in);
    check({tag, ".consumed"}, {30'd0, out_valid_out, in_ready_out}, 32'd1);
  endtask

  initial begin
    int cycles;
    rst_in       = 1'b1;
    x_in         = 32'd0;
    y_in         = 32'd0;
    in_valid_in  = 1'b0;
    out_ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst.ready", {31'd0, in_ready_out}, 32'd1);
    check("rst.valid", {31'd0, out_valid_out}, 32'd0);
    check("rst.diff", diff_out, 32'd0);
    check("rst.flags", {30'd0, borrow_out, ovf_out}, 32'd0);

    run_op("5m3",    32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0);
    run_op("3m5",    32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("minm1",  32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("chunkb", 32'h0000_00FF,  32'h0000_0100,  32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("maxmn1", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1);
    run_op("zero",   32'd0,          32'd0,          32'h0000_0000, 1'b0, 1'b0);
    run_op("eqbig",  32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0000_0000, 1'b0, 1'b0);

    // Backpressure with operand pulses during RUN and DONE
    out_ready_in = 1'b0;
    @(negedge clk_in);
    x_in = 32'd100;
    y_in = 32'd1;
    in_valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    x_in = 32'h0BAD_F00D;
    y_in = 32'h0000_0007;
    check("bp.run_ready", {31'd0, in_ready_out}, 32'd0);
    cycles = 0;
    while (!out_valid_out && cycles < 20) begin
      @(posedge clk_in);
      @(negedge clk_in);
      cycles++;
    end
    check("bp.latency", cycles, 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check("bp.hold_diff", diff_out, 32'd99);
      check("bp.hold_ctl", {29'd0, out_valid_out, in_ready_out, borrow_out}, 32'b100);
    end
    in_valid_in = 1'b0;
    out_ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    check("bp.released", {30'd0, out_valid_out, in_ready_out}, 32'd1);
    check("bp.diff_kept", diff_out, 32'd99);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("bp.no_capture", {30'd0, out_valid_out, in_ready_out}, 32'd1);

    // Reset on the second RUN edge
    x_in = 32'h1234_5678;
    y_in = 32'd1;
    in_valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    in_valid_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("mrst.ctl", {30'd0, out_valid_out, in_ready_out}, 32'd1);
    check("mrst.diff", diff_out, 32'd0);
    check("mrst.flags", {30'd0, borrow_out, ovf_out}, 32'd0);
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    check("mrst.no_result", {31'd0, out_valid_out}, 32'd0);
    run_op("post_rst", 32'd10, 32'd4, 32'h0000_0006, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub32_seq.md
# sub32_seq

Multi-cycle 32-bit subtractor: the inverse operation to the adder cells in the arithmetic library. It computes x − y as x + ~y + 1 over several cycles, CHUNK bits per cycle, with a carry chain held between cycles. Operands enter and results leave through valid/ready handshakes. It serves datapaths that need a difference, borrow and overflow without a single full-width combinational ripple path.

## Interface
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per RUN cycle. WIDTH must be an integer multiple of CHUNK; any other value is unsupported.
- clk_in  input  1  clock; all logic on the rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- x_in  input  WIDTH  minuend, sampled on accept.
- y_in  input  WIDTH  subtrahend, sampled on accept.
- in_valid_in  input  1  operand pair valid.
- in_ready_out  output  1  block can accept operands.
- diff_out  output  WIDTH  x − y modulo 2^WIDTH.
- borrow_out  output  1  1 when x < y (unsigned), i.e. the inverted final carry.
- ovf_out  output  1  signed two's-complement overflow (see Configuration).
- out_valid_out  output  1  result valid.
- out_ready_in  input  1  consumer takes the result.

## Operation
- States:
  - IDLE: in_ready_out=1. On in_valid_in=1, latch x_in and ~y_in, set carry=1 and chunk index=0, then go to RUN.
  - RUN: each cycle, add chunk[idx] of x, chunk[idx] of ~y and the carry. Write the CHUNK-bit sum into the matching slice of the diff register, store the carry-out and increment idx. On the last chunk (idx = WIDTH/CHUNK − 1), go to DONE.
  - DONE: out_valid_out=1 and all outputs held stable. On out_ready_in=1, go to IDLE.
- Handshake gating:
  - in_ready_out is 0 in RUN and DONE.
  - in_valid_in is ignored in RUN and DONE, and operands are not captured.
- Result flags:
  - borrow_out = ~carry after the last chunk.
  - ovf_out = (x[MSB] ≠ y[MSB]) & (diff[MSB] ≠ x[MSB]).
- Operands are captured in internal registers, so x_in and y_in may change freely after the accept edge.
- The internal carry width is one bit. No state survives between operations except through the output registers.

## Timing
- Reset values: state IDLE, in_ready_out 1, out_valid_out 0, diff_out 0, borrow_out 0, ovf_out 0, idx 0.
- Accept edge E0 is the rising edge with state IDLE and in_valid_in=1.
- RUN occupies edges E1..EN, where N = WIDTH/CHUNK (4 by default). out_valid_out rises after EN, giving an accept-to-valid latency of N cycles.
- The result is consumed on the first edge with out_valid_out=1 and out_ready_in=1.
- in_ready_out returns to 1 in the cycle after consumption; a back-to-back operation costs N+2 cycles minimum.
- Backpressure: while out_ready_in=0, the block stays in DONE indefinitely with diff_out, borrow_out and ovf_out unchanged.
- While out_valid_out=0, diff_out holds the previous result, with slices overwritten progressively during RUN. Consumers must qualify it with out_valid_out.
- Reset mid-operation: rst_in=1 on any edge forces reset values on that edge. A partial result is discarded and never presented.
- Reset has priority over every simultaneous event.

## Configuration
- SUB32_SEQ_OVF_EN defined: ovf_out is computed as above and registered on the transition into DONE.
- SUB32_SEQ_OVF_EN undefined: the overflow logic is removed and ovf_out is tied to 0. All other behaviour and timing are identical.

## Test plan
- x=5, y=3, out_ready_in=1 → diff_out=0x00000002, borrow_out=0, ovf_out=0, out_valid_out 4 cycles after accept.
- x=3, y=5 → diff_out=0xFFFFFFFE, borrow_out=1, ovf_out=0.
- x=0x80000000, y=1 → diff_out=0x7FFFFFFF, borrow_out=0, ovf_out=1 with SUB32_SEQ_OVF_EN, 0 without it.
- x=0x000000FF, y=0x00000100 (borrow crossing a chunk boundary) → diff_out=0xFFFFFFFF, borrow_out=1.
- Hold out_ready_in=0 for 10 cycles after valid, pulse in_valid_in with new operands during RUN and DONE → outputs stable, in_ready_out=0, new operands not captured; result consumed on release.
- Assert rst_in on the 2nd RUN cycle → next cycle in IDLE, out_valid_out=0, diff_out=0. A following operation x=10, y=4 yields 0x00000006.
